// File: rtl/stc_lock_sequencer.sv
// Acquisition/lock controller for the STC downconverter datapath.
// Sequences loop clear, AGC settling, channel-estimate peak search and lock
// verification, then watches the magnitude stream for loss of lock.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   enable_i                : run sequencer; low forces IDLE
//   mag_en_i, mag_i         : magnitude sample strobe and unsigned magnitude
//   acq_threshold_i         : acquire threshold (mag >= thr counts as a hit)
//   loss_threshold_i        : loss threshold (mag < thr counts as a miss)
//   settle_cycles_i         : strobes spent in SETTLE (0 behaves as 1)
//   timeout_cycles_i        : strobes allowed in SEARCH/VERIFY (0 = never)
//   locked_o                : high while in LOCKED
//   agc_run_o               : AGC gate, high in SETTLE/SEARCH/VERIFY
//   loop_clear_o            : one-cycle loop integrator clear (CLEAR state)
//   state_o                 : current state code
//   acq_count_o             : saturating count of VERIFY->LOCKED transitions
module stc_lock_sequencer #(
  parameter int unsigned MAG_WIDTH  = 13,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned HIT_COUNT  = 4,
  parameter int unsigned MISS_COUNT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable_i,
  input  logic                 mag_en_i,
  input  logic [MAG_WIDTH-1:0] mag_i,
  input  logic [MAG_WIDTH-1:0] acq_threshold_i,
  input  logic [MAG_WIDTH-1:0] loss_threshold_i,
  input  logic [CNT_WIDTH-1:0] settle_cycles_i,
  input  logic [CNT_WIDTH-1:0] timeout_cycles_i,
  output logic                 locked_o,
  output logic                 agc_run_o,
  output logic                 loop_clear_o,
  output logic [2:0]           state_o,
  output logic [7:0]           acq_count_o
);

  localparam int unsigned HIT_W  = unsigned'($clog2(HIT_COUNT + 1));
  localparam int unsigned MISS_W = unsigned'($clog2(MISS_COUNT + 1));

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_SEARCH = 3'd3;
  localparam logic [2:0] ST_VERIFY = 3'd4;
  localparam logic [2:0] ST_LOCKED = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] settle_cnt_q, settle_cnt_d;
  logic [CNT_WIDTH-1:0] timeout_cnt_q, timeout_cnt_d;
  logic [HIT_W-1:0]     hit_cnt_q, hit_cnt_d;
  logic [MISS_W-1:0]    miss_cnt_q, miss_cnt_d;
  logic [7:0]           acq_count_q, acq_count_d;
  logic                 locked_q, agc_run_q, loop_clear_q;

  logic                 is_hit, is_miss, timeout_now, lock_now;
  logic [CNT_WIDTH-1:0] settle_last, timeout_inc;
  logic [7:0]           acq_inc;

  // Strobe qualifiers shared by the search/verify/locked branches
  always_comb begin
    is_hit      = (mag_i >= acq_threshold_i);
    is_miss     = (mag_i < loss_threshold_i);
    settle_last = (settle_cycles_i == '0) ? '0 : settle_cycles_i - CNT_WIDTH'(1);
    timeout_now = (timeout_cycles_i != '0) &&
                  (timeout_cnt_q == timeout_cycles_i - CNT_WIDTH'(1));
    // Saturate so an unbounded search with timeout disabled never wraps
    timeout_inc = (timeout_cnt_q == '1) ? timeout_cnt_q : timeout_cnt_q + CNT_WIDTH'(1);
    acq_inc     = (acq_count_q == 8'hFF) ? acq_count_q : acq_count_q + 8'd1;
    lock_now    = 1'b0;
    if (state_q == ST_SEARCH)
      lock_now = is_hit && (HIT_COUNT == 1);
    else if (state_q == ST_VERIFY)
      lock_now = is_hit && (hit_cnt_q + HIT_W'(1) == HIT_W'(HIT_COUNT));
  end

  // Next-state and counter update
  always_comb begin
    state_d       = state_q;
    settle_cnt_d  = settle_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    acq_count_d   = acq_count_q;

    if (!enable_i) begin
      state_d       = ST_IDLE;
      settle_cnt_d  = '0;
      timeout_cnt_d = '0;
      hit_cnt_d     = '0;
      miss_cnt_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_CLEAR;
        ST_CLEAR: begin
          state_d       = ST_SETTLE;
          settle_cnt_d  = '0;
          timeout_cnt_d = '0;
          hit_cnt_d     = '0;
          miss_cnt_d    = '0;
        end
        ST_SETTLE: begin
          if (mag_en_i) begin
            if (settle_cnt_q == settle_last) begin
              state_d      = ST_SEARCH;
              settle_cnt_d = '0;
            end else begin
              settle_cnt_d = settle_cnt_q + CNT_WIDTH'(1);
            end
          end
        end
        ST_SEARCH, ST_VERIFY: begin
          if (mag_en_i) begin
            timeout_cnt_d = timeout_inc;
            if (lock_now) begin
              state_d       = ST_LOCKED;
              acq_count_d   = acq_inc;
              timeout_cnt_d = '0;
              hit_cnt_d     = '0;
            end else if (timeout_now) begin
              // Restart acquisition; CLEAR zeroes the remaining counters
              state_d = ST_CLEAR;
            end else if (is_hit) begin
              state_d   = ST_VERIFY;
              hit_cnt_d = (state_q == ST_SEARCH) ? HIT_W'(1) : hit_cnt_q + HIT_W'(1);
            end else begin
              state_d   = ST_SEARCH;
              hit_cnt_d = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (mag_en_i) begin
            if (!is_miss) begin
              miss_cnt_d = '0;
            end else if (miss_cnt_q + MISS_W'(1) == MISS_W'(MISS_COUNT)) begin
              state_d    = ST_CLEAR;
              miss_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + MISS_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, counters and registered Moore decodes of the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      settle_cnt_q  <= '0;
      timeout_cnt_q <= '0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      acq_count_q   <= '0;
      locked_q      <= 1'b0;
      agc_run_q     <= 1'b0;
      loop_clear_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      acq_count_q   <= acq_count_d;
      locked_q      <= (state_d == ST_LOCKED);
      agc_run_q     <= (state_d == ST_SETTLE) || (state_d == ST_SEARCH) ||
                       (state_d == ST_VERIFY);
      loop_clear_q  <= (state_d == ST_CLEAR);
    end
  end

  assign state_o      = state_q;
  assign locked_o     = locked_q;
  assign agc_run_o    = agc_run_q;
  assign loop_clear_o = loop_clear_q;
  assign acq_count_o  = acq_count_q;

endmodule

// File: tb/tb_stc_lock_sequencer.sv
// Directed bench for stc_lock_sequencer: a vector table for acquisition,
// then hand-written sequences for loss of lock, timeout, enable and reset.
module tb_stc_lock_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        mag_en;
  logic [12:0] mag;
  logic [12:0] acq_thr, loss_thr;
  logic [15:0] settle_cyc, timeout_cyc;
  logic        locked, agc_run, loop_clear;
  logic [2:0]  state;
  logic [7:0]  acq_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stc_lock_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .enable_i         (enable),
    .mag_en_i         (mag_en),
    .mag_i            (mag),
    .acq_threshold_i  (acq_thr),
    .loss_threshold_i (loss_thr),
    .settle_cycles_i  (settle_cyc),
    .timeout_cycles_i (timeout_cyc),
    .locked_o         (locked),
    .agc_run_o        (agc_run),
    .loop_clear_o     (loop_clear),
    .state_o          (state),
    .acq_count_o      (acq_count)
  );

  typedef struct {
    logic       en;
    logic       me;
    logic [12:0] m;
    logic [2:0] st;
    logic       lk;
    logic       agc;
    logic       clr;
    logic [7:0] acq;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic en, input logic me, input int m,
                             input int st, input logic lk, input logic agc,
                             input logic clr, input int acq);
    vec_t r;
    r.en = en; r.me = me; r.m = 13'(m); r.st = 3'(st);
    r.lk = lk; r.agc = agc; r.clr = clr; r.acq = 8'(acq);
    return r;
  endfunction

  // One clock: drive inputs just after the edge, sample 1 ns after the next edge
  task automatic tick(input logic en, input logic me, input int m);
    enable = en;
    mag_en = me;
    mag    = 13'(m);
    @(posedge clk);
    #1;
    mag_en = 1'b0;
  endtask

  task automatic check(input string name, input int st, input logic lk,
                       input logic agc, input logic clr, input int acq);
    checks++;
    if (state !== 3'(st) || locked !== lk || agc_run !== agc ||
        loop_clear !== clr || acq_count !== 8'(acq)) begin
      errors++;
      $display("FAIL %s: got state=%0d locked=%b agc=%b clr=%b acq=%0d, want state=%0d locked=%b agc=%b clr=%b acq=%0d",
               name, state, locked, agc_run, loop_clear, acq_count,
               st, lk, agc, clr, acq);
    end
  endtask

  // Strobe followed by three idle clocks (magEn every 4 clk)
  task automatic strobe(input int m);
    tick(1'b1, 1'b1, m);
    repeat (3) tick(1'b1, 1'b0, 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mag_en = 1'b0; mag = '0;
    acq_thr = 13'd1000; loss_thr = 13'd500;
    settle_cyc = 16'd3; timeout_cyc = 16'd0;
    tick(1'b0, 1'b0, 0);
    tick(1'b0, 1'b0, 0);
    reset = 1'b0;
    check("reset", 0, 0, 0, 0, 0);

    // Acquisition: clear, settle, search, failed verify, boundary values, lock
    tbl.push_back(v(1, 0,    0, 1, 0, 0, 1, 0));  // IDLE -> CLEAR
    tbl.push_back(v(1, 1, 1200, 2, 0, 1, 0, 0));  // strobe in CLEAR ignored
    tbl.push_back(v(1, 1,    0, 2, 0, 1, 0, 0));  // settle 1
    tbl.push_back(v(1, 1,    0, 2, 0, 1, 0, 0));  // settle 2
    tbl.push_back(v(1, 0,    0, 2, 0, 1, 0, 0));
    tbl.push_back(v(1, 1,    0, 3, 0, 1, 0, 0));  // settle 3 -> SEARCH
    tbl.push_back(v(1, 1, 1200, 4, 0, 1, 0, 0));  // hit 1
    tbl.push_back(v(1, 0,    0, 4, 0, 1, 0, 0));
    tbl.push_back(v(1, 1, 1200, 4, 0, 1, 0, 0));  // hit 2
    tbl.push_back(v(1, 1,  900, 3, 0, 1, 0, 0));  // miss -> SEARCH
    tbl.push_back(v(1, 1, 1200, 4, 0, 1, 0, 0));
    tbl.push_back(v(1, 1, 1200, 4, 0, 1, 0, 0));
    tbl.push_back(v(1, 1, 1200, 4, 0, 1, 0, 0));  // hit 3
    tbl.push_back(v(1, 1,  999, 3, 0, 1, 0, 0));  // just below threshold
    tbl.push_back(v(1, 1, 1000, 4, 0, 1, 0, 0));  // equal counts as hit
    tbl.push_back(v(1, 1, 1200, 4, 0, 1, 0, 0));
    tbl.push_back(v(1, 1, 1200, 4, 0, 1, 0, 0));
    tbl.push_back(v(1, 1, 1200, 5, 1, 0, 0, 1));  // 4th hit -> LOCKED
    tbl.push_back(v(1, 0,    0, 5, 1, 0, 0, 1));
    foreach (tbl[i]) begin
      tick(tbl[i].en, tbl[i].me, int'(tbl[i].m));
      check($sformatf("vec%0d", i), tbl[i].st, tbl[i].lk, tbl[i].agc,
            tbl[i].clr, tbl[i].acq);
    end

    // Loss of lock: 7 misses, reset by 500 (not below), then 8 misses drop lock
    repeat (7) strobe(400);
    check("locked_after_7_miss", 5, 1, 0, 0, 1);
    strobe(500);
    repeat (7) strobe(400);
    check("locked_after_reset_7", 5, 1, 0, 0, 1);
    timeout_cyc = 16'd5;
    tick(1'b1, 1'b1, 400);
    check("loss_clear", 1, 0, 0, 1, 1);
    tick(1'b1, 1'b0, 0);
    check("loss_settle", 2, 0, 1, 0, 1);

    // Timeout after 5 SEARCH strobes
    repeat (3) strobe(0);
    check("search_again", 3, 0, 1, 0, 1);
    repeat (4) strobe(0);
    check("search_before_to", 3, 0, 1, 0, 1);
    tick(1'b1, 1'b1, 0);
    check("timeout_clear", 1, 0, 0, 1, 1);
    tick(1'b1, 1'b0, 0);
    check("timeout_settle", 2, 0, 1, 0, 1);

    // Timeout disabled: long search never restarts
    timeout_cyc = 16'd0;
    repeat (3) strobe(0);
    repeat (20) strobe(0);
    check("no_timeout", 3, 0, 1, 0, 1);

    // enable=0 in VERIFY with a simultaneous strobe
    tick(1'b1, 1'b1, 1200);
    check("verify_entry", 4, 0, 1, 0, 1);
    tick(1'b0, 1'b1, 1200);
    check("disable_verify", 0, 0, 0, 0, 1);

    // Re-acquire: settleCycles=0 acts as 1; lock wins over timeout on same strobe
    settle_cyc = 16'd0; timeout_cyc = 16'd4;
    tick(1'b1, 1'b0, 0);
    check("reen_clear", 1, 0, 0, 1, 1);
    tick(1'b1, 1'b0, 0);
    tick(1'b1, 1'b1, 0);
    check("settle_zero", 3, 0, 1, 0, 1);
    repeat (3) tick(1'b1, 1'b1, 1200);
    check("verify_3", 4, 0, 1, 0, 1);
    tick(1'b1, 1'b1, 1200);
    check("lock_beats_timeout", 5, 1, 0, 0, 2);

    // enable=0 in LOCKED with a strobe
    tick(1'b0, 1'b1, 0);
    check("disable_locked", 0, 0, 0, 0, 2);

    // Reset mid-SETTLE
    settle_cyc = 16'd3;
    tick(1'b1, 1'b0, 0);
    tick(1'b1, 1'b0, 0);
    tick(1'b1, 1'b1, 0);
    check("mid_settle", 2, 0, 1, 0, 2);
    reset = 1'b1;
    tick(1'b1, 1'b1, 0);
    check("reset_mid_settle", 0, 0, 0, 0, 0);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
